// File: rtl/intl_fault_latch.sv
// intl_fault_latch: debounces and masks interlock flags, latches faults and drives the MPS trip
module intl_fault_latch #(
  parameter int N_INTL = 16,
  parameter int DB_W   = 16,
  parameter int FW     = $clog2(N_INTL)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_INTL-1:0] i_intl_raw,
  input  logic [N_INTL-1:0] i_intl_mask,
  input  logic [DB_W-1:0]   i_debounce,
  input  logic              i_clr,
  output logic [N_INTL-1:0] o_intl_latched,
  output logic              o_trip,
  output logic [FW-1:0]     o_first_fault,
  output logic              o_first_valid,
  output logic [15:0]       o_trip_cnt,
  output logic [1:0]        o_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, TRIP = 2'd1, CLEAR = 2'd2} state_t;
  state_t            r_state, w_next;
  logic [DB_W-1:0]   r_cnt [N_INTL];
  logic [N_INTL-1:0] w_act, w_qual, r_latched;
  logic [FW-1:0]     r_first, w_low;
  logic              r_valid, r_trip;
  logic [15:0]       r_trip_cnt;

  function automatic logic [FW-1:0] lowest(input logic [N_INTL-1:0] v);
    lowest = '0;
    for (int k = N_INTL - 1; k >= 0; k--)
      if (v[k]) lowest = FW'(k);
  endfunction

  // Masked raw flags qualify once their debounce count has reached D
  always_comb begin
    w_act = i_intl_raw & ~i_intl_mask;
    w_qual = '0;
    for (int k = 0; k < N_INTL; k++)
      w_qual[k] = w_act[k] & (r_cnt[k] >= i_debounce);
    w_low = lowest(w_qual);
  end

  // Per-channel debounce counters clamp at D, so lowering D reloads them to D
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)
      for (int k = 0; k < N_INTL; k++) r_cnt[k] <= '0;
    else
      for (int k = 0; k < N_INTL; k++)
        r_cnt[k] <= !w_act[k] ? '0 : (r_cnt[k] >= i_debounce) ? i_debounce : r_cnt[k] + 1'b1;

  // Next state: clear is only honoured in TRIP; CLEAR re-trips if faults persist
  always_comb begin
    w_next = (r_state == IDLE)  ? (|w_qual ? TRIP : IDLE) :
             (r_state == TRIP)  ? (i_clr ? CLEAR : TRIP) :
             (r_state == CLEAR) ? (|w_qual ? TRIP : IDLE) : IDLE;
  end

  // State, latched faults, first-fault record and trip counter
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state    <= IDLE;
      r_latched  <= '0;
      r_first    <= '0;
      r_valid    <= 1'b0;
      r_trip_cnt <= '0;
      r_trip     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_trip  <= (w_next == TRIP) || (w_next == CLEAR);
      case (r_state)
        IDLE:
          if (|w_qual) begin
            r_latched  <= w_qual;
            r_first    <= w_low;
            r_valid    <= 1'b1;
            r_trip_cnt <= (r_trip_cnt == 16'hFFFF) ? r_trip_cnt : r_trip_cnt + 16'd1;
          end
        TRIP: r_latched <= r_latched | w_qual;
        CLEAR: begin
          r_latched <= w_qual;
          r_first   <= |w_qual ? w_low : '0;
          r_valid   <= |w_qual;
        end
        default: ;
      endcase
    end

  assign o_intl_latched = r_latched;
  assign o_trip         = r_trip;
  assign o_first_fault  = r_first;
  assign o_first_valid  = r_valid;
  assign o_trip_cnt     = r_trip_cnt;
  assign o_state        = r_state;
endmodule

// File: doc/intl_fault_latch.md
Name: intl_fault_latch

Overview:
- Interlock collection stage directly downstream of the oscillation interlock detector and sibling interlock sources.
- Debounces N raw interlock flags per channel, honours a mask, and latches qualified faults.
- Drives a single trip output to the MPS output-stage disable path.
- Records the first-fault channel and a saturating trip count for the host, with a clear request returning the block to armed.

Parameters:
N_INTL, 16, number of interlock channels (2..32)
DB_W, 16, width of per-channel debounce counter and i_debounce

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_intl_raw  in  N_INTL  raw interlock flags (bit k = channel k; oscillation flag is one of them), already synchronous to i_clk
i_intl_mask  in  N_INTL  1 = channel ignored (never qualifies, counter held at 0)
i_debounce  in  DB_W  D: channel qualifies on the (D+1)th consecutive sampled-high edge
i_clr  in  1  clear request, single-cycle pulse, acted on only in TRIP
o_intl_latched  out  N_INTL  latched qualified faults
o_trip  out  1  1 whenever state is TRIP or CLEAR
o_first_fault  out  $clog2(N_INTL)  index of first fault of current trip event
o_first_valid  out  1  o_first_fault is meaningful
o_trip_cnt  out  16  number of IDLE->TRIP transitions, saturating at 0xFFFF
o_state  out  2  FSM state encoding

Behaviour:
- Reset (i_rst=1, async): state=IDLE, all counters 0, o_intl_latched=0, o_trip=0, o_first_fault=0, o_first_valid=0, o_trip_cnt=0.
- Active channel act[k] = i_intl_raw[k] & ~i_intl_mask[k].
- Per-channel counter cnt[k] (DB_W bits) updates each edge:
  - if act[k]: cnt[k] <= min(cnt[k]+1, D)
  - else: cnt[k] <= 0
  - cnt[k] never exceeds D. If D is lowered below cnt[k], the next edge loads D.
- Qualification is combinational: qual[k] = act[k] & (cnt[k] >= D).
- D=0: a fault latches on the first edge raw is sampled high. D=3: it latches on the 4th consecutive high edge. Any single low sample restarts the count.
- FSM, encoding IDLE=0, TRIP=1, CLEAR=2 (3 unused; goes to IDLE):
  - IDLE:
    - if qual != 0: go to TRIP; o_intl_latched <= qual.
    - o_first_fault <= lowest set index of qual; o_first_valid <= 1.
    - o_trip_cnt <= o_trip_cnt+1, saturating at 0xFFFF.
  - TRIP:
    - o_intl_latched <= o_intl_latched | qual every edge. Later faults accumulate; first fault is unchanged.
    - i_clr=1: go to CLEAR. The same-edge OR of qual still applies.
  - CLEAR (exactly one cycle):
    - o_intl_latched <= qual. Only still-qualified faults survive.
    - if qual != 0: go to TRIP; o_first_fault <= lowest set index of qual; o_first_valid=1; o_trip_cnt not incremented.
    - else: go to IDLE; o_first_fault <= 0; o_first_valid <= 0.
- i_clr in IDLE or CLEAR is ignored.
- Mask changes never clear existing latched bits. A newly masked channel's counter goes to 0 next edge.
- o_trip is registered from next state: it rises on the same edge that o_intl_latched becomes non-zero. Latency from first sampled-high raw edge to o_trip=1 is D+1 edges counted inclusively, i.e. visible after edge D.
- o_trip stays 1 through CLEAR. Deassertion occurs only on the CLEAR->IDLE edge.
- Simultaneous qualification on several channels in IDLE: all are latched; first fault = lowest index.
- Reset mid-TRIP clears everything, including o_trip_cnt.

Test Plan:
- D=2, mask=0, raw[5] high for 3 edges -> o_trip=1 and o_intl_latched=0x0020 after 3rd edge, o_first_fault=5, o_first_valid=1, o_trip_cnt=1. Raw high for only 2 edges, then low -> no trip.
- D=0, raw[3] and raw[9] rise on the same edge -> o_intl_latched=0x0208, o_first_fault=3. Then raw[12] rises in TRIP -> latched=0x1208, first fault still 3.
- In TRIP, all raw low, i_clr pulse -> one cycle in CLEAR with o_trip=1, then IDLE, o_trip=0, latched=0, o_first_valid=0, o_trip_cnt unchanged.
- In TRIP, raw[7] still high (D=0), i_clr pulse -> CLEAR then TRIP, latched=0x0080, o_first_fault=7, o_trip_cnt not incremented.
- mask[4]=1, raw[4] held high 100 cycles -> no trip. Clear mask[4] with D=1 -> trip after 2 edges.
- Preload o_trip_cnt to 0xFFFE via 3 fewer trip cycles (or force), cause two more trips -> o_trip_cnt holds 0xFFFF. Assert i_rst mid-TRIP -> all outputs 0 immediately, without waiting for a clock edge.
